// File: rtl/mnist_infer_pkg.sv
// mnist_infer_pkg: FSM states, default frame geometry and the signed compare shared by the inference controller.
package mnist_infer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SCAN, DONE} state_t;
  localparam int PIX_PER_FRAME = 28 * 28;
  localparam int IDX_W = $clog2(10);
  localparam int PIX_CNT_W = $clog2(PIX_PER_FRAME);
  function automatic logic sgt(input logic signed [31:0] a, input logic signed [31:0] b);
    return a > b;
  endfunction
endpackage

// File: rtl/mnist_argmax_seq.sv
// mnist_argmax_seq: serial signed argmax over a captured logit vector, one compare per enabled cycle.
// INFER_MARGIN_EN adds runner-up tracking and a best-minus-second margin.
module mnist_argmax_seq
  import mnist_infer_pkg::*;
#(
  parameter int N = 8,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     i_start,
  input  logic [NUM_CLASSES*N-1:0] i_vec,
  output logic                     o_last,
  output logic [IDX_W-1:0]         o_idx,
`ifdef INFER_MARGIN_EN
  output logic [N:0]               o_margin,
`endif
  output logic [N-1:0]             o_best
);
  logic [NUM_CLASSES*N-1:0] r_vec;
  logic [IDX_W-1:0] r_ptr, r_idx;
  logic [N-1:0] r_best, w_x;
  logic r_run, w_gt;
  assign w_x = r_vec[r_ptr*N +: N];
  assign w_gt = sgt(32'($signed(w_x)), 32'($signed(r_best)));
  assign o_last = r_run && r_ptr == IDX_W'(NUM_CLASSES - 1);
  assign o_idx = r_idx;
  assign o_best = r_best;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
      r_ptr <= '0;
      r_idx <= '0;
      r_best <= '0;
      r_run <= 1'b0;
    end else if (ce) begin
      if (i_start) begin
        r_vec <= i_vec;
        r_best <= i_vec[N-1:0];
        r_idx <= '0;
        r_ptr <= IDX_W'(1);
        r_run <= 1'b1;
      end else if (r_run) begin
        if (w_gt) begin
          r_best <= w_x;
          r_idx <= r_ptr;
        end
        r_ptr <= r_ptr + 1'b1;
        r_run <= !o_last;
      end
    end
  end
`ifdef INFER_MARGIN_EN
  logic [N-1:0] r_sec;
  assign o_margin = {r_best[N-1], r_best} - {r_sec[N-1], r_sec};
  // runner-up starts at the most negative value so any real element displaces it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sec <= '0;
    else if (ce) begin
      if (i_start) r_sec <= {1'b1, {(N-1){1'b0}}};
      else if (r_run && w_gt) r_sec <= r_best;
      else if (r_run && sgt(32'($signed(w_x)), 32'($signed(r_sec)))) r_sec <= w_x;
    end
  end
`endif
endmodule

// File: rtl/mnist_infer_ctrl.sv
// mnist_infer_ctrl: frame-level MNIST inference controller (pixel admission, forwarding, argmax result).
// INFER_MARGIN_EN adds the margin output.
module mnist_infer_ctrl
  import mnist_infer_pkg::*;
#(
  parameter int N = 8,
  parameter int IN_CH = 1,
  parameter int IMG_SIZE = 28,
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ce,
  input  logic                             weight_load_done,
  input  logic                             pix_vld,
  input  logic [IN_CH*N-1:0]               pix_din,
  output logic                             pix_rdy,
  output logic                             net_vld,
  output logic [IN_CH*N-1:0]               net_din,
  input  logic [NUM_CLASSES*N-1:0]         net_dout,
  input  logic                             net_dout_vld,
  input  logic                             net_dout_end,
  output logic                             result_vld,
  output logic [$clog2(NUM_CLASSES)-1:0]   class_idx,
  output logic [N-1:0]                     class_score,
  output logic [CNT_W-1:0]                 frame_cnt,
`ifdef INFER_MARGIN_EN
  output logic [N:0]                       margin,
`endif
  output logic                             seq_err
);
  localparam int PPF = IMG_SIZE * IMG_SIZE;
  localparam int PCW = PPF > 1 ? $clog2(PPF) : 1;
  localparam int IW = $clog2(NUM_CLASSES);
  state_t r_state;
  logic [PCW-1:0] r_cnt;
  logic w_xfer, w_start, w_last;
  logic [IW-1:0] w_idx;
  logic [N-1:0] w_best;
  assign pix_rdy = r_state == LOAD && ce;
  assign w_xfer = pix_vld && pix_rdy;
  assign w_start = ce && r_state == WAIT && net_dout_vld && net_dout_end;
`ifdef INFER_MARGIN_EN
  logic [N:0] w_margin;
`endif
  mnist_argmax_seq #(.N(N), .NUM_CLASSES(NUM_CLASSES), .IDX_W(IW)) u_argmax (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .i_start(w_start),
    .i_vec(net_dout),
    .o_last(w_last),
    .o_idx(w_idx),
`ifdef INFER_MARGIN_EN
    .o_margin(w_margin),
`endif
    .o_best(w_best)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      net_vld <= 1'b0;
      net_din <= '0;
      result_vld <= 1'b0;
      class_idx <= '0;
      class_score <= '0;
      frame_cnt <= '0;
      seq_err <= 1'b0;
`ifdef INFER_MARGIN_EN
      margin <= '0;
`endif
    end else if (ce) begin
      net_vld <= w_xfer;
      result_vld <= 1'b0;
      if (w_xfer) net_din <= pix_din;
      if (net_dout_vld && r_state != WAIT) seq_err <= 1'b1;
      case (r_state)
        IDLE: if (weight_load_done) begin
          r_state <= LOAD;
          r_cnt <= '0;
        end
        LOAD: if (w_xfer) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == PCW'(PPF - 1)) r_state <= WAIT;
        end
        WAIT: if (w_start) r_state <= SCAN;
        SCAN: if (w_last) r_state <= DONE;
        DONE: begin
          result_vld <= 1'b1;
          class_idx <= w_idx;
          class_score <= w_best;
`ifdef INFER_MARGIN_EN
          margin <= w_margin;
`endif
          frame_cnt <= frame_cnt + 1'b1;
          r_cnt <= '0;
          r_state <= weight_load_done ? LOAD : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
